// File: rtl/bpsk_tx_pkg.sv
// Shared constants and types for the BPSK transmit modulator.
package bpsk_tx_pkg;
  localparam int DEF_ACC_W  = 28;
  localparam int DEF_OUT_W  = 16;
  localparam int DEF_LUT_AW = 8;

  // Half a turn in DDS phase units; adding it flips the carrier polarity.
  localparam logic [DEF_ACC_W-1:0] PI_OFS = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/bpsk_carrier_tx_if.sv
// Symbol-bit valid/ready handshake into the modulator.
interface bpsk_carrier_tx_if;
  logic sym_valid;
  logic sym_ready;
  logic sym_bit;

  modport master (output sym_valid, output sym_bit, input sym_ready);
  modport slave  (input sym_valid, input sym_bit, output sym_ready);
endinterface

// File: rtl/sine_qlut.sv
// Registered quarter-wave sine ROM: folded index + sign in, signed sample out.
module sine_qlut #(
  parameter int OUT_W  = 16,
  parameter int LUT_AW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vld,
  input  logic [LUT_AW-1:0]       addr,
  input  logic                    neg,
  output logic signed [OUT_W-1:0] y
);
  localparam int MAG_W = OUT_W - 1;
  localparam int DEPTH = 2 ** LUT_AW;
  localparam int AMP   = 2 ** (OUT_W - 1) - 1;

  // Half-bin offset keeps every entry nonzero and below full scale, so negation is safe.
  function automatic int qsin(input int i);
    real x, t, s;
    x = 3.14159265358979323846 / 2.0 * ($itor(i) + 0.5) / $itor(DEPTH);
    t = x;
    s = x;
    for (int k = 1; k < 10; k++) begin
      t = -t * x * x / $itor((2 * k) * (2 * k + 1));
      s = s + t;
    end
    return $rtoi($itor(AMP) * s + 0.5);
  endfunction

  logic [MAG_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam int V = qsin(i);
    assign rom[i] = MAG_W'(V);
  end

  logic [MAG_W-1:0] mag;
  assign mag = rom[addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    y <= '0;
    else if (!vld) y <= '0;
    else if (neg)  y <= -$signed({1'b0, mag});
    else           y <= $signed({1'b0, mag});
  end
endmodule

// File: rtl/bpsk_carrier_tx.sv
// BPSK carrier modulator: free-running DDS, symbol FSM, two-stage sine pipeline.
// Optional differential encoding when DIFF_ENC_EN is defined.
module bpsk_carrier_tx import bpsk_tx_pkg::*; #(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SPS    = 16,
  parameter int LUT_AW = DEF_LUT_AW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [ACC_W-1:0]        fcw,
  bpsk_carrier_tx_if.slave        sym,
  output logic signed [OUT_W-1:0] y,
  output logic                    y_valid,
  output logic                    underrun,
  output logic                    busy
);
  localparam int CW     = $clog2(SPS);
  localparam int PH_W   = LUT_AW + 2;
  localparam int STAGES = 2;
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [ACC_W-1:0]    acc;
  logic [PH_W-1:0]     acc_d;
  logic                tx_bit, nxt_bit, hs;
  logic [STAGES:0]     vld_pipe;
  logic [PH_W-1:0]     ph;
  logic [LUT_AW-1:0]   s1_idx;
  logic                s1_neg;

  assign sym.sym_ready = en & ((state == IDLE) | (cnt == LAST));
  assign hs            = sym.sym_valid & sym.sym_ready;
  assign busy          = vld_pipe[0];
  assign y_valid       = vld_pipe[STAGES];

`ifdef DIFF_ENC_EN
  // tx_bit doubles as the previous encoded bit; only reset clears it.
  assign nxt_bit = tx_bit ^ sym.sym_bit;
`else
  assign nxt_bit = sym.sym_bit;
`endif

  // acc_d lags acc by one clock so a symbol's first sample uses the handshake-cycle phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      acc_d <= '0;
    end else begin
      acc_d <= acc[ACC_W-1 -: PH_W];
      if (en) acc <= acc + fcw;
    end
  end

  // vld_pipe[0] is the registered RUN flag; higher bits track it through S1 and S2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_bit   <= 1'b0;
      underrun <= 1'b0;
      vld_pipe <= '0;
    end else begin
      underrun               <= 1'b0;
      vld_pipe[STAGES:1]     <= vld_pipe[STAGES-1:0];
      if (!en) begin
        state       <= IDLE;
        vld_pipe[0] <= 1'b0;
      end else begin
        case (state)
          IDLE: if (hs) begin
            tx_bit      <= nxt_bit;
            cnt         <= '0;
            state       <= RUN;
            vld_pipe[0] <= 1'b1;
          end
          RUN: begin
            if (cnt != LAST) begin
              cnt <= cnt + CW'(1);
            end else if (hs) begin
              tx_bit <= nxt_bit;
              cnt    <= '0;
            end else begin
              state       <= IDLE;
              vld_pipe[0] <= 1'b0;
              underrun    <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Only the top PH_W phase bits matter; a pi offset just flips the MSB.
  assign ph = acc_d + (tx_bit ? PI_OFS[DEF_ACC_W-1 -: PH_W] : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_idx <= '0;
      s1_neg <= 1'b0;
    end else begin
      s1_idx <= ph[PH_W-2] ? ~ph[PH_W-3 -: LUT_AW] : ph[PH_W-3 -: LUT_AW];
      s1_neg <= ph[PH_W-1];
    end
  end

  sine_qlut #(.OUT_W(OUT_W), .LUT_AW(LUT_AW)) u_lut (
    .clk   (clk),
    .reset (reset),
    .vld   (vld_pipe[1]),
    .addr  (s1_idx),
    .neg   (s1_neg),
    .y     (y)
  );
endmodule

// File: tb/tb_bpsk_carrier_tx.sv
// Directed bench for bpsk_carrier_tx: sine-model scoreboard keyed by expected output cycle.
module tb_bpsk_carrier_tx;
  import bpsk_tx_pkg::*;

  localparam int SPS   = 16;
  localparam int ACC_W = DEF_ACC_W;
  localparam int OUT_W = DEF_OUT_W;

  typedef struct {
    int                      cyc;
    logic signed [OUT_W-1:0] val;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    en = 1'b0;
  logic [ACC_W-1:0]        fcw = '0;
  logic signed [OUT_W-1:0] y;
  logic                    y_valid, underrun, busy;

  bpsk_carrier_tx_if sym_if ();

  bpsk_carrier_tx #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SPS(SPS), .LUT_AW(DEF_LUT_AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .fcw      (fcw),
    .sym      (sym_if),
    .y        (y),
    .y_valid  (y_valid),
    .underrun (underrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int                      cyc  = 0;
  int                      nvec = 0;
  int                      nerr = 0;
  exp_t                    q[$];
  logic signed [OUT_W-1:0] cap[$];
  logic signed [OUT_W-1:0] ref0[SPS];
  logic [ACC_W-1:0]        mdl_acc;
`ifdef DIFF_ENC_EN
  bit                      mdl_prev;
`endif

  always @(posedge clk or negedge reset)
    if (!reset) mdl_acc <= '0;
    else if (en) mdl_acc <= mdl_acc + fcw;

  // Ideal sampled sine at the centre of the 10-bit phase bin.
  function automatic logic signed [OUT_W-1:0] ref_smp(input logic [ACC_W-1:0] ph);
    real th, s;
    int  m;
    logic [9:0] p;
    p  = ph[ACC_W-1 -: 10];
    th = 2.0 * 3.14159265358979 * ($itor(p) + 0.5) / 1024.0;
    s  = $sin(th);
    m  = $rtoi(32767.0 * ((s < 0.0) ? -s : s) + 0.5);
    return (s < 0.0) ? OUT_W'(-m) : OUT_W'(m);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (y_valid === 1'b1) cap.push_back(y);
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("y_valid", y_valid, 1);
      chk("y", y, e.val);
    end else begin
      chk("y_valid_idle", y_valid, 0);
      chk("y_idle", y, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Handshake one bit at the coming edge; returns at the negedge of the cnt==0 cycle.
  task automatic send(input bit b, output int c);
    bit tx;
    logic [ACC_W-1:0] ph0;
`ifdef DIFF_ENC_EN
    tx = mdl_prev ^ b;
    mdl_prev = tx;
`else
    tx = b;
`endif
    sym_if.sym_valid = 1'b1;
    sym_if.sym_bit   = b;
    #1;
    chk("sym_ready_hs", sym_if.sym_ready, 1);
    c   = cyc;
    ph0 = mdl_acc + (tx ? ACC_W'(PI_OFS) : '0);
    for (int k = 0; k < SPS; k++)
      q.push_back('{cyc: c + 3 + k, val: ref_smp(ph0 + ACC_W'(k) * fcw)});
    @(negedge clk);
    sym_if.sym_valid = 1'b0;
    sym_if.sym_bit   = 1'b0;
    chk("busy_run", busy, 1);
    chk("sym_ready_mid", sym_if.sym_ready, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    q.delete();
`ifdef DIFF_ENC_EN
    mdl_prev = 1'b0;
`endif
    idle(2);
    reset = 1'b1;
  endtask

  initial begin
    int c;
    sym_if.sym_valid = 1'b0;
    sym_if.sym_bit   = 1'b0;
    en  = 1'b1;
    fcw = ACC_W'(1) << 24;
    idle(3);
    chk("rst_y", y, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sym_ready", sym_if.sym_ready, 1);

    // Bits 0,0 from acc=0, then underrun.
    reset = 1'b1;
    cap.delete();
    send(1'b0, c); idle(SPS - 1);
    send(1'b0, c); idle(SPS - 1);
    idle(1);
    chk("underrun_pulse", underrun, 1);
    chk("busy_idle", busy, 0);
    chk("sym_ready_idle", sym_if.sym_ready, 1);
    idle(1);
    chk("underrun_clear", underrun, 0);
    chk("sym_ready_idle2", sym_if.sym_ready, 1);
    idle(3);
    chk("t1_count", cap.size(), 2 * SPS);
    chk("t1_first", cap[0], 101);
    chk("t1_peak_pos", cap[4], 32767);
    chk("t1_half", cap[8], -101);
    chk("t1_peak_neg", cap[12], -32767);
    chk("t1_period", cap[16], 101);
    for (int i = 0; i < SPS; i++) ref0[i] = cap[SPS + i];

    // Restart after underrun: phase continues from the free-running accumulator.
    send(1'b1, c); idle(SPS - 1); idle(5);

    // Bits 0,1: second symbol is the exact negation of the all-zero run.
    do_reset();
    cap.delete();
    send(1'b0, c); idle(SPS - 1);
    send(1'b1, c); idle(SPS - 1); idle(5);
    chk("t2_count", cap.size(), 2 * SPS);
    for (int i = 0; i < SPS; i++) chk("t2_negation", cap[SPS + i], -ref0[i]);

    // Reset at cnt=5: outputs clear at once, accumulator restarts from zero.
    do_reset();
    send(1'b0, c); idle(5);
    reset = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_y", y, 0);
    chk("mid_rst_y_valid", y_valid, 0);
    chk("mid_rst_busy", busy, 0);
    idle(2);
    reset = 1'b1;
    cap.delete();
    send(1'b0, c); idle(SPS - 1); idle(5);
    chk("post_rst_first", cap[0], 101);

    // en dropped at cnt=8: samples up to cnt 8 drain, no underrun.
    cap.delete();
    send(1'b1, c); idle(8);
    en = 1'b0;
    while (q.size() > 0 && q[$].cyc > c + 3 + 8) void'(q.pop_back());
    idle(1);
    chk("en_off_busy", busy, 0);
    chk("en_off_underrun", underrun, 0);
    chk("en_off_sym_ready", sym_if.sym_ready, 0);
    idle(4);
    chk("en_off_count", cap.size(), 9);
    en = 1'b1;
    send(1'b0, c); idle(SPS - 1); idle(5);

    // Bits 1,1,0: polarity relative to the bit-0 reference.
    do_reset();
    cap.delete();
    send(1'b1, c); idle(SPS - 1);
    send(1'b1, c); idle(SPS - 1);
    send(1'b0, c); idle(SPS - 1); idle(5);
    chk("t5_sym0", cap[4], -32767);
`ifdef DIFF_ENC_EN
    chk("t5_sym1", cap[SPS + 4], 32767);
`else
    chk("t5_sym1", cap[SPS + 4], -32767);
`endif
    chk("t5_sym2", cap[2 * SPS + 4], 32767);

    // fcw=0: constant +101 then -101.
    fcw = '0;
    do_reset();
    cap.delete();
    send(1'b0, c); idle(SPS - 1);
    send(1'b1, c); idle(SPS - 1); idle(5);
    chk("t6_count", cap.size(), 2 * SPS);
    for (int i = 0; i < 2 * SPS; i++) chk("t6_dc", cap[i], (i < SPS) ? 101 : -101);

    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
